// File: rtl/cpa_pipe_stage.sv
// cpa_pipe_stage: two-stage lookahead carry-propagate adder with valid/ready handshake.
// Optional CPA_ZERO_FLAG_EN adds a registered out_zero flag alongside out_sum.
module cpa_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CPA_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);
  localparam int NN = WIDTH / 4;
  localparam int NB = WIDTH / 16;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p, r_g;
  logic             r_cin;
  logic [NN-1:0]    r_gm, r_pm;
  logic             w_adv1, w_adv2;
  logic [WIDTH-1:0] w_p, w_g, w_c, w_sum;
  logic [NN-1:0]    w_gm, w_pm;
  logic [NN:0]      w_c4;

  // Sum-of-products lookahead: carry out of the low n positions of a 4-wide group.
  function automatic logic f_la(input logic [3:0] g, input logic [3:0] p, input logic c, input int n);
    logic t, pp;
    t = 1'b0;
    pp = 1'b1;
    for (int m = n - 1; m >= 0; m--) begin
      t = t | (pp & g[m]);
      pp = pp & p[m];
    end
    return t | (pp & c);
  endfunction

  assign w_adv2   = !out_valid | out_ready;
  assign w_adv1   = !r_s1_valid | w_adv2;
  assign in_ready = w_adv1;
  assign w_p      = in_sum ^ in_carry;
  assign w_g      = in_sum & in_carry;

  always_comb begin
    w_gm = '0;
    w_pm = '0;
    for (int k = 0; k < NN; k++) begin
      w_gm[k] = f_la(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0, 4);
      w_pm[k] = &w_p[4*k +: 4];
    end
  end

  // Nibble carries resolved per 16-bit block; each block's carry-out feeds the next block.
  always_comb begin
    w_c4 = '0;
    w_c  = '0;
    w_c4[0] = r_cin;
    for (int b = 0; b < NB; b++)
      for (int j = 1; j <= 4; j++)
        w_c4[4*b+j] = f_la(r_gm[4*b +: 4], r_pm[4*b +: 4], w_c4[4*b], j);
    for (int k = 0; k < NN; k++)
      for (int i = 0; i < 4; i++)
        w_c[4*k+i] = f_la(r_g[4*k +: 4], r_p[4*k +: 4], w_c4[k], i);
    w_sum = r_p ^ w_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_cin      <= 1'b0;
      r_gm       <= '0;
      r_pm       <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_cout   <= 1'b0;
`ifdef CPA_ZERO_FLAG_EN
      out_zero   <= 1'b0;
`endif
    end else begin
      if (w_adv1) r_s1_valid <= in_valid;
      if (w_adv1 && in_valid) begin
        r_p   <= w_p;
        r_g   <= w_g;
        r_cin <= in_cin;
        r_gm  <= w_gm;
        r_pm  <= w_pm;
      end
      if (w_adv2) out_valid <= r_s1_valid;
      if (w_adv2 && r_s1_valid) begin
        out_sum  <= w_sum;
        out_cout <= w_c4[NN];
`ifdef CPA_ZERO_FLAG_EN
        out_zero <= (w_sum == '0);
`endif
      end
    end
  end
endmodule

// File: tb/tb_cpa_pipe_stage.sv
// tb_cpa_pipe_stage: directed table, back-pressure, reset and random traffic against a queue-based model.
module tb_cpa_pipe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [31:0] in_sum, in_carry, out_sum;
  logic        in_valid64, in_ready64, out_valid64, out_cout64, in_cin64;
  logic [63:0] in_sum64, in_carry64, out_sum64;
`ifdef CPA_ZERO_FLAG_EN
  logic        out_zero, out_zero64;
`endif

  always #5 clk = ~clk;

  cpa_pipe_stage #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef CPA_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  cpa_pipe_stage #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_sum(in_sum64), .in_carry(in_carry64), .in_cin(in_cin64),
    .out_valid(out_valid64), .out_ready(1'b1), .out_sum(out_sum64), .out_cout(out_cout64)
`ifdef CPA_ZERO_FLAG_EN
    , .out_zero(out_zero64)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t        tbl[9];
  logic [32:0] q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sampled at negedge, i.e. the handshake the next posedge will commit.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("in_ready_model", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      if (prev_stall) chk("stall_hold", {31'b0, out_valid, out_cout, out_sum}, {31'b0, 1'b1, prev_res});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 64'(out_valid), 64'd0);
        else begin
          logic [32:0] e;
          e = q.pop_front();
          chk("result", {31'b0, out_cout, out_sum}, {31'b0, e});
`ifdef CPA_ZERO_FLAG_EN
          chk("zero_flag", 64'(out_zero), 64'(e[31:0] == 32'd0));
`endif
          n_out++;
        end
      end
      if (in_valid && in_ready) q.push_back({1'b0, in_sum} + {1'b0, in_carry} + 33'(in_cin));
      prev_stall <= out_valid && !out_ready;
      prev_res   <= {out_cout, out_sum};
    end
  end

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
    in_valid = 1'b1; in_sum = a; in_carry = b; in_cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, idx, acc, seen, first, last, tmo, base;
    tbl[0] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    tbl[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    tbl[5] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
    tbl[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
    tbl[7] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
    tbl[8] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_cin = 1'b0; out_ready = 1'b1;
    in_valid64 = 1'b0; in_sum64 = '0; in_carry64 = '0; in_cin64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", {31'b0, out_cout, out_sum}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    foreach (tbl[i]) begin
      send_one(tbl[i].a, tbl[i].b, tbl[i].c, lat);
      chk("table_latency", 64'(lat), 64'd2);
      chk("table_sum", {31'b0, out_cout, out_sum}, {31'b0, tbl[i].co, tbl[i].s});
`ifdef CPA_ZERO_FLAG_EN
      chk("table_zero", 64'(out_zero), 64'(tbl[i].s == 32'd0));
`endif
    end
    @(posedge clk); #1;

    // Back-pressure: four items offered while the consumer stalls.
    out_ready = 1'b0; idx = 0; base = n_out;
    in_valid = 1'b1; in_sum = 32'h1000_0001; in_carry = 32'h0000_0000; in_cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); acc = int'(in_ready);
      @(posedge clk); #1;
      idx += acc;
      in_sum = 32'h1000_0001 + 32'(idx); in_carry = 32'(idx * 3); in_cin = idx[0];
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head", {31'b0, out_valid, out_sum}, {31'b0, 1'b1, 32'h1000_0001});
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    tmo = 0;
    while (idx < 4 && tmo < 50) begin
      @(negedge clk); acc = int'(in_ready);
      @(posedge clk); #1;
      idx += acc; tmo++;
      in_sum = 32'h1000_0001 + 32'(idx); in_carry = 32'(idx * 3); in_cin = idx[0];
      if (idx >= 4) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_all_out", 64'(n_out - base), 64'd4);

    // Throughput: 100 back-to-back random pairs.
    seen = 0; first = -1; last = -1; base = n_out;
    for (int k = 0; k < 104; k++) begin
      in_valid = (k < 100);
      in_sum = $urandom; in_carry = $urandom; in_cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid) begin
        seen++; last = k;
        if (first < 0) first = k;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("tp_count", 64'(seen), 64'd100);
    chk("tp_span", 64'(last - first), 64'd99);
    chk("tp_scoreboard", 64'(n_out - base), 64'd100);

    // Random valid/ready traffic.
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_sum = $urandom; in_carry = $urandom; in_cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rand_drained", 64'(q.size()), 64'd0);

    // Reset with two results in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    in_sum = 32'h0000_0005; in_carry = 32'h0000_0007; in_cin = 1'b0;
    @(posedge clk); #1;
    in_sum = 32'h0000_0009;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_sum", {31'b0, out_cout, out_sum}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1; seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    chk("no_output_after_reset", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // 64-bit instance corner cases.
    in_valid64 = 1'b1; in_sum64 = 64'h8000_0000_0000_0000; in_carry64 = 64'h8000_0000_0000_0000; in_cin64 = 1'b0;
    @(posedge clk); #1;
    in_sum64 = 64'hFFFF_FFFF_FFFF_FFFF; in_carry64 = 64'h0; in_cin64 = 1'b1;
    @(posedge clk); #1;
    in_sum64 = 64'h0123_4567_89AB_CDEF; in_carry64 = 64'h1111_1111_1111_1111; in_cin64 = 1'b1;
    chk("w64_a_valid", 64'(out_valid64), 64'd1);
    chk("w64_a_sum", out_sum64, 64'd0);
    chk("w64_a_cout", 64'(out_cout64), 64'd1);
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    chk("w64_b_sum", out_sum64, 64'd0);
    chk("w64_b_cout", 64'(out_cout64), 64'd1);
    @(posedge clk); #1;
    chk("w64_c_sum", out_sum64, 64'h1234_5678_9ABC_DF01);
    chk("w64_c_cout", 64'(out_cout64), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
